// File: rtl/aes_encrypt_core.sv
// Iterative AES-128/192/256 encryptor: one round per clock, key schedule expanded
// combinationally from the registered key, ciphertext held until the next completion.
module aes_encrypt_core #(
  parameter int N  = 128,
  parameter int Nr = 10,
  parameter int Nk = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [127:0]   in,
  input  logic [N-1:0]   key,
  output logic [127:0]   out,
  output logic           busy,
  output logic           done
);
  localparam int NW = 4 * (Nr + 1);
  localparam int RW = $clog2(Nr + 1);
  localparam logic [RW-1:0] LAST = RW'(Nr);

  if (!((N == 128 && Nr == 10 && Nk == 4) || (N == 192 && Nr == 12 && Nk == 6) ||
        (N == 256 && Nr == 14 && Nk == 8))) begin : g_bad_params
    $error("aes_encrypt_core: unsupported (N, Nr, Nk) combination");
  end

  function automatic logic [7:0] sbox(input logic [7:0] x);
    case (x)
      8'h00: sbox=8'h63; 8'h01: sbox=8'h7c; 8'h02: sbox=8'h77; 8'h03: sbox=8'h7b; 8'h04: sbox=8'hf2; 8'h05: sbox=8'h6b; 8'h06: sbox=8'h6f; 8'h07: sbox=8'hc5; 8'h08: sbox=8'h30; 8'h09: sbox=8'h01; 8'h0a: sbox=8'h67; 8'h0b: sbox=8'h2b; 8'h0c: sbox=8'hfe; 8'h0d: sbox=8'hd7; 8'h0e: sbox=8'hab; 8'h0f: sbox=8'h76;
      8'h10: sbox=8'hca; 8'h11: sbox=8'h82; 8'h12: sbox=8'hc9; 8'h13: sbox=8'h7d; 8'h14: sbox=8'hfa; 8'h15: sbox=8'h59; 8'h16: sbox=8'h47; 8'h17: sbox=8'hf0; 8'h18: sbox=8'had; 8'h19: sbox=8'hd4; 8'h1a: sbox=8'ha2; 8'h1b: sbox=8'haf; 8'h1c: sbox=8'h9c; 8'h1d: sbox=8'ha4; 8'h1e: sbox=8'h72; 8'h1f: sbox=8'hc0;
      8'h20: sbox=8'hb7; 8'h21: sbox=8'hfd; 8'h22: sbox=8'h93; 8'h23: sbox=8'h26; 8'h24: sbox=8'h36; 8'h25: sbox=8'h3f; 8'h26: sbox=8'hf7; 8'h27: sbox=8'hcc; 8'h28: sbox=8'h34; 8'h29: sbox=8'ha5; 8'h2a: sbox=8'he5; 8'h2b: sbox=8'hf1; 8'h2c: sbox=8'h71; 8'h2d: sbox=8'hd8; 8'h2e: sbox=8'h31; 8'h2f: sbox=8'h15;
      8'h30: sbox=8'h04; 8'h31: sbox=8'hc7; 8'h32: sbox=8'h23; 8'h33: sbox=8'hc3; 8'h34: sbox=8'h18; 8'h35: sbox=8'h96; 8'h36: sbox=8'h05; 8'h37: sbox=8'h9a; 8'h38: sbox=8'h07; 8'h39: sbox=8'h12; 8'h3a: sbox=8'h80; 8'h3b: sbox=8'he2; 8'h3c: sbox=8'heb; 8'h3d: sbox=8'h27; 8'h3e: sbox=8'hb2; 8'h3f: sbox=8'h75;
      8'h40: sbox=8'h09; 8'h41: sbox=8'h83; 8'h42: sbox=8'h2c; 8'h43: sbox=8'h1a; 8'h44: sbox=8'h1b; 8'h45: sbox=8'h6e; 8'h46: sbox=8'h5a; 8'h47: sbox=8'ha0; 8'h48: sbox=8'h52; 8'h49: sbox=8'h3b; 8'h4a: sbox=8'hd6; 8'h4b: sbox=8'hb3; 8'h4c: sbox=8'h29; 8'h4d: sbox=8'he3; 8'h4e: sbox=8'h2f; 8'h4f: sbox=8'h84;
      8'h50: sbox=8'h53; 8'h51: sbox=8'hd1; 8'h52: sbox=8'h00; 8'h53: sbox=8'hed; 8'h54: sbox=8'h20; 8'h55: sbox=8'hfc; 8'h56: sbox=8'hb1; 8'h57: sbox=8'h5b; 8'h58: sbox=8'h6a; 8'h59: sbox=8'hcb; 8'h5a: sbox=8'hbe; 8'h5b: sbox=8'h39; 8'h5c: sbox=8'h4a; 8'h5d: sbox=8'h4c; 8'h5e: sbox=8'h58; 8'h5f: sbox=8'hcf;
      8'h60: sbox=8'hd0; 8'h61: sbox=8'hef; 8'h62: sbox=8'haa; 8'h63: sbox=8'hfb; 8'h64: sbox=8'h43; 8'h65: sbox=8'h4d; 8'h66: sbox=8'h33; 8'h67: sbox=8'h85; 8'h68: sbox=8'h45; 8'h69: sbox=8'hf9; 8'h6a: sbox=8'h02; 8'h6b: sbox=8'h7f; 8'h6c: sbox=8'h50; 8'h6d: sbox=8'h3c; 8'h6e: sbox=8'h9f; 8'h6f: sbox=8'ha8;
      8'h70: sbox=8'h51; 8'h71: sbox=8'ha3; 8'h72: sbox=8'h40; 8'h73: sbox=8'h8f; 8'h74: sbox=8'h92; 8'h75: sbox=8'h9d; 8'h76: sbox=8'h38; 8'h77: sbox=8'hf5; 8'h78: sbox=8'hbc; 8'h79: sbox=8'hb6; 8'h7a: sbox=8'hda; 8'h7b: sbox=8'h21; 8'h7c: sbox=8'h10; 8'h7d: sbox=8'hff; 8'h7e: sbox=8'hf3; 8'h7f: sbox=8'hd2;
      8'h80: sbox=8'hcd; 8'h81: sbox=8'h0c; 8'h82: sbox=8'h13; 8'h83: sbox=8'hec; 8'h84: sbox=8'h5f; 8'h85: sbox=8'h97; 8'h86: sbox=8'h44; 8'h87: sbox=8'h17; 8'h88: sbox=8'hc4; 8'h89: sbox=8'ha7; 8'h8a: sbox=8'h7e; 8'h8b: sbox=8'h3d; 8'h8c: sbox=8'h64; 8'h8d: sbox=8'h5d; 8'h8e: sbox=8'h19; 8'h8f: sbox=8'h73;
      8'h90: sbox=8'h60; 8'h91: sbox=8'h81; 8'h92: sbox=8'h4f; 8'h93: sbox=8'hdc; 8'h94: sbox=8'h22; 8'h95: sbox=8'h2a; 8'h96: sbox=8'h90; 8'h97: sbox=8'h88; 8'h98: sbox=8'h46; 8'h99: sbox=8'hee; 8'h9a: sbox=8'hb8; 8'h9b: sbox=8'h14; 8'h9c: sbox=8'hde; 8'h9d: sbox=8'h5e; 8'h9e: sbox=8'h0b; 8'h9f: sbox=8'hdb;
      8'ha0: sbox=8'he0; 8'ha1: sbox=8'h32; 8'ha2: sbox=8'h3a; 8'ha3: sbox=8'h0a; 8'ha4: sbox=8'h49; 8'ha5: sbox=8'h06; 8'ha6: sbox=8'h24; 8'ha7: sbox=8'h5c; 8'ha8: sbox=8'hc2; 8'ha9: sbox=8'hd3; 8'haa: sbox=8'hac; 8'hab: sbox=8'h62; 8'hac: sbox=8'h91; 8'had: sbox=8'h95; 8'hae: sbox=8'he4; 8'haf: sbox=8'h79;
      8'hb0: sbox=8'he7; 8'hb1: sbox=8'hc8; 8'hb2: sbox=8'h37; 8'hb3: sbox=8'h6d; 8'hb4: sbox=8'h8d; 8'hb5: sbox=8'hd5; 8'hb6: sbox=8'h4e; 8'hb7: sbox=8'ha9; 8'hb8: sbox=8'h6c; 8'hb9: sbox=8'h56; 8'hba: sbox=8'hf4; 8'hbb: sbox=8'hea; 8'hbc: sbox=8'h65; 8'hbd: sbox=8'h7a; 8'hbe: sbox=8'hae; 8'hbf: sbox=8'h08;
      8'hc0: sbox=8'hba; 8'hc1: sbox=8'h78; 8'hc2: sbox=8'h25; 8'hc3: sbox=8'h2e; 8'hc4: sbox=8'h1c; 8'hc5: sbox=8'ha6; 8'hc6: sbox=8'hb4; 8'hc7: sbox=8'hc6; 8'hc8: sbox=8'he8; 8'hc9: sbox=8'hdd; 8'hca: sbox=8'h74; 8'hcb: sbox=8'h1f; 8'hcc: sbox=8'h4b; 8'hcd: sbox=8'hbd; 8'hce: sbox=8'h8b; 8'hcf: sbox=8'h8a;
      8'hd0: sbox=8'h70; 8'hd1: sbox=8'h3e; 8'hd2: sbox=8'hb5; 8'hd3: sbox=8'h66; 8'hd4: sbox=8'h48; 8'hd5: sbox=8'h03; 8'hd6: sbox=8'hf6; 8'hd7: sbox=8'h0e; 8'hd8: sbox=8'h61; 8'hd9: sbox=8'h35; 8'hda: sbox=8'h57; 8'hdb: sbox=8'hb9; 8'hdc: sbox=8'h86; 8'hdd: sbox=8'hc1; 8'hde: sbox=8'h1d; 8'hdf: sbox=8'h9e;
      8'he0: sbox=8'he1; 8'he1: sbox=8'hf8; 8'he2: sbox=8'h98; 8'he3: sbox=8'h11; 8'he4: sbox=8'h69; 8'he5: sbox=8'hd9; 8'he6: sbox=8'h8e; 8'he7: sbox=8'h94; 8'he8: sbox=8'h9b; 8'he9: sbox=8'h1e; 8'hea: sbox=8'h87; 8'heb: sbox=8'he9; 8'hec: sbox=8'hce; 8'hed: sbox=8'h55; 8'hee: sbox=8'h28; 8'hef: sbox=8'hdf;
      8'hf0: sbox=8'h8c; 8'hf1: sbox=8'ha1; 8'hf2: sbox=8'h89; 8'hf3: sbox=8'h0d; 8'hf4: sbox=8'hbf; 8'hf5: sbox=8'he6; 8'hf6: sbox=8'h42; 8'hf7: sbox=8'h68; 8'hf8: sbox=8'h41; 8'hf9: sbox=8'h99; 8'hfa: sbox=8'h2d; 8'hfb: sbox=8'h0f; 8'hfc: sbox=8'hb0; 8'hfd: sbox=8'h54; 8'hfe: sbox=8'hbb; 8'hff: sbox=8'h16;
      default: sbox = 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    sub_word = {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input int i);
    case (i)
      1: rcon = 8'h01;  2: rcon = 8'h02;  3: rcon = 8'h04;  4: rcon = 8'h08;  5: rcon = 8'h10;
      6: rcon = 8'h20;  7: rcon = 8'h40;  8: rcon = 8'h80;  9: rcon = 8'h1b; 10: rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  function automatic logic [32*NW-1:0] expand(input logic [N-1:0] k);
    logic [31:0] w [NW];
    logic [31:0] t;
    for (int i = 0; i < Nk; i++) begin
      w[i] = k[N-1-32*i -: 32];
      expand[32*NW-1-32*i -: 32] = w[i];
    end
    for (int i = Nk; i < NW; i++) begin
      t = w[i-1];
      if (i % Nk == 0)
        t = sub_word({t[23:0], t[31:24]}) ^ {rcon(i / Nk), 24'h0};
      else if (Nk == 8 && i % Nk == 4)
        t = sub_word(t);
      w[i] = w[i-Nk] ^ t;
      expand[32*NW-1-32*i -: 32] = w[i];
    end
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    xt = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // SubBytes fused with ShiftRows: output (row r, col c) takes input (row r, col c+r).
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sub_shift[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      mix[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      mix[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      mix[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      mix[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
  endfunction

  // IDLE: waiting for start (busy=0) | RUN: rounds 1..Nr in progress
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} st_t;
  st_t st, st_nxt;

  logic [127:0]    state;
  logic [N-1:0]    key_reg;
  logic [RW-1:0]   round;
  logic [32*NW-1:0] w_all;
  logic [127:0]    rk [Nr+1];
  logic            load, step, fin;

  assign w_all = expand(key_reg);
  always_comb begin
    for (int r = 0; r <= Nr; r++) rk[r] = w_all[32*NW-1-128*r -: 128];
  end

  always_comb begin
    st_nxt = st;
    load   = 1'b0;
    step   = 1'b0;
    fin    = 1'b0;
    case (st)
      IDLE: if (start) begin load = 1'b1; st_nxt = RUN; end
      RUN: begin
        if (round == LAST) begin fin = 1'b1; st_nxt = IDLE; end
        else step = 1'b1;
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) st <= IDLE;
    else       st <= st_nxt;
  end

  assign busy = (st == RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= '0;
      out     <= '0;
      key_reg <= '0;
      round   <= '0;
      done    <= 1'b0;
    end else begin
      done <= fin;
      if (load) begin
        key_reg <= key;
        state   <= in ^ key[N-1 -: 128];
        round   <= RW'(1);
      end
      if (step) begin
        state <= mix(sub_shift(state)) ^ rk[round];
        round <= round + 1'b1;
      end
      if (fin) begin
        out   <= sub_shift(state) ^ rk[Nr];
        round <= '0;
      end
    end
  end
endmodule

// File: tb/tb_aes_encrypt_core.sv
// Scoreboard bench for aes_encrypt_core: AES-128/192/256 instances driven with
// FIPS-197 vectors; a per-instance monitor checks ciphertext and completion cycle.
module tb_aes_encrypt_core;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start0, start1, start2;
  logic [127:0] in0, in1, in2;
  logic [127:0] key0;
  logic [191:0] key1;
  logic [255:0] key2;
  logic [127:0] out0, out1, out2;
  logic busy0, busy1, busy2, done0, done1, done2;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [127:0] data;
    int           cyc;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  localparam logic [127:0] PA  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [255:0] KA  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] CA  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PB  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KB  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [127:0] CB  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  aes_encrypt_core u128 (
    .clk(clk), .reset(reset), .start(start0), .in(in0), .key(key0),
    .out(out0), .busy(busy0), .done(done0));
  aes_encrypt_core #(.N(192), .Nr(12), .Nk(6)) u192 (
    .clk(clk), .reset(reset), .start(start1), .in(in1), .key(key1),
    .out(out1), .busy(busy1), .done(done1));
  aes_encrypt_core #(.N(256), .Nr(14), .Nk(8)) u256 (
    .clk(clk), .reset(reset), .start(start2), .in(in2), .key(key2),
    .out(out2), .busy(busy2), .done(done2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pop(input int d, input logic [127:0] o);
    exp_t e;
    int n;
    n = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
    if (n == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_done%0d: got done with out=%h expected no completion", d, o);
    end else begin
      case (d)
        0: e = q0.pop_front();
        1: e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      check($sformatf("ciphertext%0d", d), o, e.data);
      check($sformatf("latency%0d", d), 128'(cyc), 128'(e.cyc));
    end
  endtask

  always @(negedge clk) if (done0 === 1'b1) pop(0, out0);
  always @(negedge clk) if (done1 === 1'b1) pop(1, out1);
  always @(negedge clk) if (done2 === 1'b1) pop(2, out2);

  // Called just after a falling edge; start is seen at the next rising edge.
  task automatic go(input int d, input logic [127:0] p, input logic [255:0] k,
                    input logic [127:0] x, input bit expect_it);
    exp_t e;
    e.data = x;
    e.cyc  = cyc + 1 + ((d == 0) ? 10 : (d == 1) ? 12 : 14);
    case (d)
      0: begin start0 = 1'b1; in0 = p; key0 = k[255:128]; if (expect_it) q0.push_back(e); end
      1: begin start1 = 1'b1; in1 = p; key1 = k[255:64];  if (expect_it) q1.push_back(e); end
      default: begin start2 = 1'b1; in2 = p; key2 = k; if (expect_it) q2.push_back(e); end
    endcase
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if ((q0.size() + q1.size() + q2.size()) != 0) begin
      bad++;
      $display("FAIL pending_blocks: got %0d outstanding expected 0", q0.size() + q1.size() + q2.size());
    end
  endtask

  initial begin
    int n;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    in0 = '0; in1 = '0; in2 = '0;
    key0 = '0; key1 = '0; key2 = '0;
    repeat (3) @(negedge clk);
    check("reset_out128", out0, 128'h0);
    check("reset_busy128", 128'(busy0), 128'(0));
    check("reset_done128", 128'(done0), 128'(0));
    check("reset_out256", out2, 128'h0);
    reset = 1'b0;
    @(negedge clk);

    go(0, PA, KA, CA, 1'b1);
    go(1, PB, K192, C192, 1'b1);
    go(2, PB, K256, C256, 1'b1);
    wait_empty();

    repeat (5) @(negedge clk);
    check("hold128", out0, CA);
    check("hold192", out1, C192);
    check("hold256", out2, C256);

    // start while busy must be ignored
    go(0, PB, KB, CB, 1'b1);
    repeat (3) @(negedge clk);
    check("busy_mid_block", 128'(busy0), 128'(1));
    go(0, PA, KA, CA, 1'b0);
    wait_empty();
    repeat (15) @(negedge clk);
    check("ignored_start_out", out0, CB);
    check("idle_after_ignore", 128'(busy0), 128'(0));

    // back-to-back: restart in the done cycle
    go(0, PA, KA, CA, 1'b1);
    n = 0;
    while (done0 !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("done_seen_b2b", 128'(done0), 128'(1));
    go(0, PB, KB, CB, 1'b1);
    repeat (4) @(negedge clk);
    check("hold_during_busy", out0, CA);
    check("busy_second_block", 128'(busy0), 128'(1));
    wait_empty();
    check("b2b_final_out", out0, CB);

    // asynchronous reset mid-round discards the block
    go(0, PA, KA, CA, 1'b1);
    repeat (3) @(negedge clk);
    check("busy_before_reset", 128'(busy0), 128'(1));
    #2;
    reset = 1'b1;
    q0.delete();
    #1;
    check("async_rst_out", out0, 128'h0);
    check("async_rst_busy", 128'(busy0), 128'(0));
    check("async_rst_done", 128'(done0), 128'(0));
    check("async_rst_out192", out1, 128'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("post_reset_out", out0, 128'h0);
    check("post_reset_busy", 128'(busy0), 128'(0));

    go(0, PB, KB, CB, 1'b1);
    wait_empty();
    check("recover_out", out0, CB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
